// File: rtl/cpu_seq_if.sv
// Bus bundle between the cpu_seq sequencer and its fetch unit, ALU and register file.
// The master modport is the sequencer side; the slave modport is the environment side.
interface cpu_seq_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_valid;
    logic [31:0] ifu_inst;
    logic [4:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [31:0] alu_next_pc;
    logic [31:0] alu_result;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        halt;
    logic [1:0]  halt_code;
    logic [31:0] inst_cnt;

    modport master (
        output ifu_req, ifu_addr, alu_op, imm, pc, rs1_addr,
        output rf_wen, rf_waddr, rf_wdata, halt, halt_code, inst_cnt,
        input  ifu_valid, ifu_inst, alu_next_pc, alu_result
    );

    modport slave (
        input  ifu_req, ifu_addr, alu_op, imm, pc, rs1_addr,
        input  rf_wen, rf_waddr, rf_wdata, halt, halt_code, inst_cnt,
        output ifu_valid, ifu_inst, alu_next_pc, alu_result
    );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: fetch, decode/execute via an external ALU,
// register-file writeback, and a sticky halt on ebreak, illegal encoding or misaligned PC.
module cpu_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic      clk,
    input  logic      rst_n,
    cpu_seq_if.master bus
);

    localparam logic [31:0] Ebreak = 32'h0010_0073;

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StWb, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  code_q, code_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] res_q, res_d;
    logic [31:0] npc_q, npc_d;

    logic [4:0]  dec_op;
    logic [31:0] dec_imm;
    logic        exec_halt;

    // Decode straight from the fetch bus so alu_op/imm are registered on entry to EXEC.
    always_comb begin
        dec_op  = 5'b0;
        dec_imm = 32'b0;
        case (bus.ifu_inst[6:0])
            7'b0010111: begin
                dec_op  = 5'b00001;
                dec_imm = {bus.ifu_inst[31:12], 12'b0};
            end
            7'b0110111: begin
                dec_op  = 5'b00010;
                dec_imm = {bus.ifu_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_op  = 5'b00100;
                dec_imm = {{11{bus.ifu_inst[31]}}, bus.ifu_inst[31], bus.ifu_inst[19:12],
                           bus.ifu_inst[20], bus.ifu_inst[30:21], 1'b0};
            end
            7'b1100111: begin
                if (bus.ifu_inst[14:12] == 3'b000) begin
                    dec_op  = 5'b01000;
                    dec_imm = {{20{bus.ifu_inst[31]}}, bus.ifu_inst[31:20]};
                end
            end
            7'b0010011: begin
                if (bus.ifu_inst[14:12] == 3'b000) begin
                    dec_op  = 5'b10000;
                    dec_imm = {{20{bus.ifu_inst[31]}}, bus.ifu_inst[31:20]};
                end
            end
            default: ;
        endcase
    end

    assign exec_halt = (inst_q == Ebreak) || (op_q == 5'b0) || (bus.alu_next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (bus.ifu_valid) state_d = StExec;
            StExec:  state_d = exec_halt ? StHalt : StWb;
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        cnt_d  = cnt_q;
        code_d = code_q;
        op_d   = op_q;
        imm_d  = imm_q;
        res_d  = res_q;
        npc_d  = npc_q;
        case (state_q)
            StFetch: begin
                if (bus.ifu_valid) begin
                    inst_d = bus.ifu_inst;
                    op_d   = dec_op;
                    imm_d  = dec_imm;
                end
            end
            StExec: begin
                // Cause priority: ebreak, then illegal, then misaligned target.
                if (inst_q == Ebreak) begin
                    code_d = 2'b00;
                end else if (op_q == 5'b0) begin
                    code_d = 2'b01;
                end else if (bus.alu_next_pc[1:0] != 2'b00) begin
                    code_d = 2'b10;
                end else begin
                    res_d = bus.alu_result;
                    npc_d = bus.alu_next_pc;
                end
            end
            StWb: begin
                pc_d  = npc_q;
                cnt_d = cnt_q + 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            inst_q <= 32'b0;
            cnt_q  <= 32'b0;
            code_q <= 2'b00;
            op_q   <= 5'b0;
            imm_q  <= 32'b0;
            res_q  <= 32'b0;
            npc_q  <= 32'b0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
            cnt_q  <= cnt_d;
            code_q <= code_d;
            op_q   <= op_d;
            imm_q  <= imm_d;
            res_q  <= res_d;
            npc_q  <= npc_d;
        end
    end

    always_comb begin
        bus.ifu_req   = (state_q == StFetch);
        bus.ifu_addr  = pc_q;
        bus.pc        = pc_q;
        bus.alu_op    = ((state_q == StExec) || (state_q == StWb)) ? op_q : 5'b0;
        bus.imm       = imm_q;
        bus.rs1_addr  = inst_q[19:15];
        bus.rf_waddr  = inst_q[11:7];
        bus.rf_wdata  = res_q;
        bus.rf_wen    = (state_q == StWb) && (inst_q[11:7] != 5'd0);
        bus.halt      = (state_q == StHalt);
        bus.halt_code = code_q;
        bus.inst_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: directed cases plus randomized instruction streams
// checked against an instruction-level reference model with its own register file.
module tb_cpu_seq;

    localparam logic [31:0] RstPc = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cpu_seq_if bus ();

    cpu_seq #(.RESET_PC(RstPc)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] rf_m [32];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_halt;
    logic        ovr_en;
    logic [31:0] ovr_npc;
    logic [31:0] rs1v;

    // Architectural effect of each ALU operation.
    function automatic void alu_fn(input logic [4:0] op, input logic [31:0] im,
                                   input logic [31:0] pcv, input logic [31:0] r1,
                                   output logic [31:0] res, output logic [31:0] npc);
        res = 32'b0;
        npc = pcv + 32'd4;
        case (op)
            5'b00001: res = pcv + im;
            5'b00010: res = im;
            5'b00100: begin res = pcv + 32'd4; npc = pcv + im; end
            5'b01000: begin res = pcv + 32'd4; npc = (r1 + im) & ~32'd1; end
            5'b10000: res = r1 + im;
            default: ;
        endcase
    endfunction

    // Instruction-level decode: kind 0 legal, 1 ebreak, 2 illegal.
    function automatic void model_dec(input logic [31:0] inst, output logic [4:0] op,
                                      output logic [31:0] im, output int kind);
        logic [31:0] i_imm, u_imm, j_imm;
        i_imm = {{20{inst[31]}}, inst[31:20]};
        u_imm = {inst[31:12], 12'b0};
        j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        op = 5'b0;
        im = 32'b0;
        kind = 2;
        if (inst == 32'h0010_0073) kind = 1;
        else if (inst[6:0] == 7'b0010111) begin op = 5'b00001; im = u_imm; kind = 0; end
        else if (inst[6:0] == 7'b0110111) begin op = 5'b00010; im = u_imm; kind = 0; end
        else if (inst[6:0] == 7'b1101111) begin op = 5'b00100; im = j_imm; kind = 0; end
        else if (inst[6:0] == 7'b1100111 && inst[14:12] == 3'b000) begin
            op = 5'b01000; im = i_imm; kind = 0;
        end else if (inst[6:0] == 7'b0010011 && inst[14:12] == 3'b000) begin
            op = 5'b10000; im = i_imm; kind = 0;
        end
    endfunction

    // Environment ALU responding to the DUT's registered operands.
    always_comb begin
        rs1v = rf_m[bus.rs1_addr];
        alu_fn(bus.alu_op, bus.imm, bus.pc, rs1v, bus.alu_result, bus.alu_next_pc);
        if (ovr_en) bus.alu_next_pc = ovr_npc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit full);
        @(negedge clk);
        rst_n = 1'b0;
        ovr_en = 1'b0;
        bus.ifu_valid = 1'b0;
        #1;
        chk("rst_req", bus.ifu_req, 32'd0);
        chk("rst_pc", bus.pc, RstPc);
        chk("rst_cnt", bus.inst_cnt, 32'd0);
        chk("rst_halt", bus.halt, 32'd0);
        chk("rst_wen", bus.rf_wen, 32'd0);
        if (full) begin
            chk("rst_code", bus.halt_code, 32'd0);
            chk("rst_op", bus.alu_op, 32'd0);
            chk("rst_imm", bus.imm, 32'd0);
            chk("rst_wdata", bus.rf_wdata, 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = RstPc;
        m_cnt = 32'd0;
        m_halt = 1'b0;
        if (full) begin
            chk("idle_req", bus.ifu_req, 32'd0);
            @(negedge clk);
            chk("idle_to_fetch", bus.ifu_req, 32'd1);
        end
    endtask

    task automatic run_inst(input logic [31:0] inst);
        logic [4:0]  eop;
        logic [31:0] eim, eres, enpc;
        logic [4:0]  rd;
        logic [1:0]  code;
        int kind;
        int n;
        n = 0;
        while (bus.ifu_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", bus.ifu_req, 32'd1);
        if (bus.ifu_req !== 1'b1) return;
        chk("ifu_addr", bus.ifu_addr, m_pc);
        model_dec(inst, eop, eim, kind);
        rd = inst[11:7];
        alu_fn(eop, eim, m_pc, rf_m[inst[19:15]], eres, enpc);
        if (ovr_en) enpc = ovr_npc;
        bus.ifu_valid = 1'b1;
        bus.ifu_inst = inst;
        @(negedge clk);
        bus.ifu_valid = 1'b0;
        bus.ifu_inst = $urandom;
        chk("exec_op", bus.alu_op, eop);
        if (kind == 0) chk("exec_imm", bus.imm, eim);
        chk("exec_req", bus.ifu_req, 32'd0);
        @(negedge clk);
        if (kind != 0 || enpc[1:0] != 2'b00) begin
            code = (kind == 1) ? 2'b00 : (kind == 2) ? 2'b01 : 2'b10;
            chk("halt", bus.halt, 32'd1);
            chk("halt_code", bus.halt_code, code);
            chk("halt_wen", bus.rf_wen, 32'd0);
            chk("halt_pc", bus.pc, m_pc);
            chk("halt_cnt", bus.inst_cnt, m_cnt);
            chk("halt_op", bus.alu_op, 32'd0);
            m_halt = 1'b1;
            return;
        end
        chk("wb_op", bus.alu_op, eop);
        chk("wb_wen", bus.rf_wen, (rd != 5'd0));
        if (rd != 5'd0) begin
            chk("wb_waddr", bus.rf_waddr, rd);
            chk("wb_wdata", bus.rf_wdata, eres);
            rf_m[rd] = eres;
        end
        @(negedge clk);
        m_pc = enpc;
        m_cnt = m_cnt + 32'd1;
        chk("ret_req", bus.ifu_req, 32'd1);
        chk("ret_wen", bus.rf_wen, 32'd0);
        chk("ret_pc", bus.pc, m_pc);
        chk("ret_cnt", bus.inst_cnt, m_cnt);
    endtask

    initial begin
        logic [31:0] r, inst;
        logic [4:0]  rd, rs;
        int sel;
        bus.ifu_valid = 1'b0;
        bus.ifu_inst = 32'b0;
        ovr_en = 1'b0;
        ovr_npc = 32'b0;
        rf_m[0] = 32'b0;
        for (int i = 1; i < 32; i++) rf_m[i] = $urandom;

        do_reset(1'b1);
        run_inst(32'h1234_50B7);
        chk("lui_imm", bus.imm, 32'h1234_5000);
        chk("lui_pc", bus.pc, 32'h8000_0004);
        chk("lui_cnt", bus.inst_cnt, 32'd1);
        run_inst(32'hFFF0_0013);
        chk("addi_imm", bus.imm, 32'hFFFF_FFFF);
        chk("addi_pc", bus.pc, 32'h8000_0008);

        do_reset(1'b0);
        run_inst(32'h0080_006F);
        chk("jal_imm", bus.imm, 32'd8);
        chk("jal_pc", bus.pc, 32'h8000_0008);
        run_inst(32'h0010_0073);
        chk("ebreak_cnt", bus.inst_cnt, 32'd1);

        do_reset(1'b0);
        run_inst(32'h0000_0000);
        for (int i = 0; i < 12; i++) begin
            bus.ifu_valid = i[0];
            bus.ifu_inst = 32'h1234_50B7;
            @(negedge clk);
            chk("halt_hold_req", bus.ifu_req, 32'd0);
            chk("halt_hold_code", {bus.halt, bus.halt_code}, 32'b101);
        end
        bus.ifu_valid = 1'b0;

        do_reset(1'b0);
        ovr_en = 1'b1;
        ovr_npc = 32'h8000_0102;
        run_inst(32'h0001_00E7);
        chk("misalign_pc", bus.pc, RstPc);
        ovr_en = 1'b0;

        // Reset dropped in WB: write must vanish in the same cycle, stale fetch ignored.
        do_reset(1'b0);
        run_inst(32'h1234_50B7);
        bus.ifu_valid = 1'b1;
        bus.ifu_inst = 32'h0000_1137;
        @(negedge clk);
        bus.ifu_valid = 1'b0;
        @(negedge clk);
        chk("mid_wb_wen", bus.rf_wen, 32'd1);
        #2;
        rst_n = 1'b0;
        bus.ifu_valid = 1'b1;
        #1;
        chk("mid_rst_wen", bus.rf_wen, 32'd0);
        chk("mid_rst_pc", bus.pc, RstPc);
        chk("mid_rst_op", bus.alu_op, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_idle_req", bus.ifu_req, 32'd0);
        @(negedge clk);
        bus.ifu_valid = 1'b0;
        chk("mid_fetch_req", bus.ifu_req, 32'd1);
        @(negedge clk);
        chk("mid_stale_ignored", bus.ifu_req, 32'd1);
        m_pc = RstPc;
        m_cnt = 32'd0;
        m_halt = 1'b0;
        run_inst(32'h0000_1137);

        for (int k = 0; k < 200; k++) begin
            if (m_halt) do_reset(1'b0);
            r = $urandom;
            rd = 5'($urandom_range(0, 31));
            rs = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1, 2: inst = {r[31:12], rd, 7'b0110111};
                3, 4:    inst = {r[31:12], rd, 7'b0010111};
                5, 6, 7: inst = {r[31:20], rs, 3'b000, rd, 7'b0010011};
                8, 9: begin
                    inst = {r[31:12], rd, 7'b1101111};
                    if ($urandom_range(0, 3) != 0) inst[22] = 1'b0;
                end
                10:      inst = {r[31:20], rs, 3'b000, rd, 7'b1100111};
                11:      inst = {r[31:15], 3'b001, rd, 7'b1100111};
                12:      inst = {r[31:7], 7'b0110011};
                13:      inst = {r[31:20], rs, 3'b000, 5'd0, 7'b0010011};
                14:      inst = {r[31:12], 5'd0, 7'b0110111};
                default: inst = 32'h0010_0073;
            endcase
            run_inst(inst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ifu_req, output, 1, instruction fetch request.
REQ-005 SHALL have port ifu_addr, output, 32, fetch address, equal to pc.
REQ-006 SHALL have port ifu_valid, input, 1, fetch data valid.
REQ-007 SHALL have port ifu_inst, input, 32, fetched instruction.
REQ-008 SHALL have port alu_op, output, 5, one-hot ALU select: bit0 auipc, bit1 lui, bit2 jal, bit3 jalr, bit4 addi.
REQ-009 SHALL have port imm, output, 32, decoded immediate to the ALU.
REQ-010 SHALL have port pc, output, 32, current PC to the ALU.
REQ-011 SHALL have port rs1_addr, output, 5, register-file read index (inst[19:15]).
REQ-012 SHALL have port alu_next_pc, input, 32, next PC from the ALU.
REQ-013 SHALL have port alu_result, input, 32, ALU result.
REQ-014 SHALL have port rf_wen, output, 1, register-file write strobe.
REQ-015 SHALL have port rf_waddr, output, 5, write index (inst[11:7]).
REQ-016 SHALL have port rf_wdata, output, 32, write data.
REQ-017 SHALL have port halt, output, 1, the core has stopped.
REQ-018 SHALL have port halt_code, output, 2, stop cause: 00 ebreak, 01 illegal, 10 misaligned PC.
REQ-019 SHALL have port inst_cnt, output, 32, count of retired instructions.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, EXEC, WB and HALT.
REQ-021 SHALL transition IDLE->FETCH unconditionally on the first edge after reset release.
REQ-022 SHALL assert ifu_req only in FETCH and hold it until ifu_valid; on ifu_valid it latches ifu_inst into inst_q and goes to EXEC.
REQ-023 SHALL ignore ifu_valid in any state other than FETCH.
REQ-024 SHALL decode in EXEC: opcode 0010111 auipc; 0110111 lui; 1101111 jal; 1100111 with funct3 000 jalr; 0010011 with funct3 000 addi.
REQ-025 SHALL go EXEC->HALT when inst_q equals 32'h0010_0073 (ebreak), with halt_code 00.
REQ-026 SHALL go EXEC->HALT with halt_code 01 for any other encoding; pc is not updated and no write occurs.
REQ-027 SHALL form imm as follows: I-type sign-extends inst[31:20]; U-type is {inst[31:12], 12'b0}; J-type sign-extends {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
REQ-028 SHALL register alu_op and imm on entry to EXEC, hold them through WB, and drive alu_op = 0 in all other states.
REQ-029 SHALL check in EXEC that alu_next_pc[1:0] == 0; if not, go to HALT with halt_code 10, with no write and no pc update.
REQ-030 SHALL otherwise register alu_result and alu_next_pc in EXEC and go to WB.
REQ-031 SHALL in WB pulse rf_wen for exactly one cycle with rf_wdata = registered result, suppressed when rf_waddr == 0.
REQ-032 SHALL in WB load pc with the registered next PC, increment inst_cnt by 1 (wrapping 32'hFFFF_FFFF->0), and return to FETCH.
REQ-033 SHALL give a retire latency of exactly 3 cycles from the ifu_valid edge to the next ifu_req (FETCH->EXEC->WB->FETCH).
REQ-034 SHALL treat HALT as absorbing: halt = 1, ifu_req = 0, rf_wen = 0, halt_code stable; only reset exits it.

Reset
REQ-035 SHALL on rst_n = 0 immediately force state IDLE, pc = RESET_PC, inst_cnt = 0, halt = 0, halt_code = 00, ifu_req = 0, rf_wen = 0, alu_op = 0, imm = 0, rf_wdata = 0, with inst_q cleared.
REQ-036 SHALL abandon any in-flight fetch or writeback on reset, with no rf_wen glitch, and a fetch returning after reset is ignored until FETCH is re-entered.

Verification
REQ-037 SHALL be verified for lui: ifu_inst 32'h1234_50B7 with alu_result 32'h1234_5000 -> alu_op 00010, imm 32'h1234_5000, rf_wen pulse with rf_waddr 1, pc 32'h8000_0004, inst_cnt 1.
REQ-038 SHALL be verified for addi with rd = 0: ifu_inst 32'hFFF0_0013 -> imm 32'hFFFF_FFFF, alu_op 10000, rf_wen stays 0, pc advances by 4.
REQ-039 SHALL be verified for jal: ifu_inst 32'h0080_006F with alu_next_pc 32'h8000_0008 -> imm 8, alu_op 00100, pc 32'h8000_0008.
REQ-040 SHALL be verified for ebreak and illegal: 32'h0010_0073 -> halt 1, code 00, inst_cnt unchanged; 32'h0000_0000 -> halt 1, code 01, ifu_req then held 0 for 10 or more cycles.
REQ-041 SHALL be verified for misaligned PC: jalr with alu_next_pc 32'h8000_0102 -> halt code 10, no rf_wen, pc unchanged.
REQ-042 SHALL be verified for reset mid-operation: rst_n dropped in WB -> same-cycle rf_wen 0, pc 32'h8000_0000, and the FSM restarts through IDLE->FETCH.
